// File: rtl/knight_pkg.sv
// ---------------------------------------------------------------------------
// knight_pkg
// Shared definitions for the KnightsTour remote command link.
//   BAUD_DIV_DEFAULT : clocks per UART bit (100 MHz / 19200 baud)
//   POS_ACK          : positive acknowledge response byte
//   asm_state_e      : command assembly states (high byte / low byte)
//   rx_state_e       : 8N1 receiver states
// ---------------------------------------------------------------------------
package knight_pkg;

    localparam int unsigned BAUD_DIV_DEFAULT = 5208;
    localparam logic [7:0]  POS_ACK          = 8'hA5;

    typedef enum logic {
        IDLE,
        WAIT_LO
    } asm_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/cmd_uart_phy.sv
// ---------------------------------------------------------------------------
// cmd_uart_phy
// Full-duplex 8N1 byte transceiver, LSB first, BAUD_DIV clocks per bit.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   rx_i            : serial input (asynchronous, idle high)
//   tx_o            : serial output (idle high)
//   tx_data_i       : byte to send, captured on an accepted trmt_i
//   trmt_i          : start transmission (ignored while busy)
//   tx_done_o       : frame fully sent; held until next accepted trmt_i
//   rx_data_o       : last received byte
//   rx_rdy_o        : 1-clk pulse after a valid stop bit
//   rx_frame_err_o  : 1-clk pulse after a stop bit sampled low
//   rx_start_o      : start-bit falling edge detected while idle
//   rx_idle_o       : receiver is idle
// ---------------------------------------------------------------------------
module cmd_uart_phy
    import knight_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       tx_o,
    input  logic [7:0] tx_data_i,
    input  logic       trmt_i,
    output logic       tx_done_o,
    output logic [7:0] rx_data_o,
    output logic       rx_rdy_o,
    output logic       rx_frame_err_o,
    output logic       rx_start_o,
    output logic       rx_idle_o
);

    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] FULL_M1 = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_M1 = BW'(BAUD_DIV / 2 - 1);

    // ------------------------------------------------------------------ RX
    logic            rx_ff1_q, rx_ff2_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [BW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_rdy_q, rx_rdy_d;
    logic            rx_ferr_q, rx_ferr_d;
    logic            rx_fall;

    // Edge history resets high, so after reset only a genuine high-to-low
    // transition on the synchronized line can start a frame.
    assign rx_fall = rx_prev_q & ~rx_ff2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ff1_q   <= 1'b1;
            rx_ff2_q   <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_rdy_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_ff1_q   <= rx_i;
            rx_ff2_q   <= rx_ff1_q;
            rx_prev_q  <= rx_ff2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_rdy_q   <= rx_rdy_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_rdy_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_M1;
                end
            end
            RX_START: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - BW'(1);
                end else if (rx_ff2_q) begin
                    // line back high at mid start bit: glitch, not a frame
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = FULL_M1;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - BW'(1);
                end else begin
                    rx_shift_d = {rx_ff2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = FULL_M1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - BW'(1);
                end else begin
                    rx_state_d = RX_IDLE;
                    rx_rdy_d   = rx_ff2_q;
                    rx_ferr_d  = ~rx_ff2_q;
                end
            end
        endcase
    end

    assign rx_data_o      = rx_shift_q;
    assign rx_rdy_o       = rx_rdy_q;
    assign rx_frame_err_o = rx_ferr_q;
    assign rx_idle_o      = (rx_state_q == RX_IDLE);
    assign rx_start_o     = (rx_state_q == RX_IDLE) && rx_fall;

    // ------------------------------------------------------------------ TX
    logic [9:0]      tx_shift_q;
    logic [BW-1:0]   tx_cnt_q;
    logic [3:0]      tx_bit_q;
    logic            tx_busy_q;
    logic            tx_done_q;

    // Shift register fills with ones, so bit 0 is the line level both while
    // idle and once the stop bit has shifted into place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else if (!tx_busy_q) begin
            if (trmt_i) begin
                tx_shift_q <= {1'b1, tx_data_i, 1'b0};
                tx_cnt_q   <= FULL_M1;
                tx_bit_q   <= '0;
                tx_busy_q  <= 1'b1;
                tx_done_q  <= 1'b0;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_q <= tx_cnt_q - BW'(1);
        end else if (tx_bit_q == 4'd9) begin
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b1;
        end else begin
            tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            tx_bit_q   <= tx_bit_q + 4'd1;
            tx_cnt_q   <= FULL_M1;
        end
    end

    assign tx_o      = tx_shift_q[0];
    assign tx_done_o = tx_done_q;

endmodule

// File: rtl/cmd_uart_wrapper.sv
// ---------------------------------------------------------------------------
// cmd_uart_wrapper
// Knight-side end of the remote command link. Assembles 16-bit commands from
// two received bytes (high first) and sends 8-bit responses back.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   RX, TX       : serial pins (idle high)
//   cmd          : last assembled command {high, low}
//   cmd_rdy      : new command valid, held until cleared
//   clr_cmd_rdy  : consumer clear pulse for cmd_rdy
//   resp, trmt   : response byte and its send strobe
//   tx_done      : response fully sent, held until next accepted trmt
// ---------------------------------------------------------------------------
module cmd_uart_wrapper
    import knight_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int unsigned TIMEOUT  = 104160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [7:0] rx_data;
    logic       rx_rdy, rx_ferr, rx_start, rx_idle;

    cmd_uart_phy #(
        .BAUD_DIV(BAUD_DIV)
    ) u_phy (
        .clk            (clk),
        .rst            (rst),
        .rx_i           (RX),
        .tx_o           (TX),
        .tx_data_i      (resp),
        .trmt_i         (trmt),
        .tx_done_o      (tx_done),
        .rx_data_o      (rx_data),
        .rx_rdy_o       (rx_rdy),
        .rx_frame_err_o (rx_ferr),
        .rx_start_o     (rx_start),
        .rx_idle_o      (rx_idle)
    );

    asm_state_e  state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            tmo_q     <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            tmo_q     <= tmo_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    // Clears are applied first so that a set later in the block wins.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        tmo_d     = tmo_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (rx_start) begin
                    cmd_rdy_d = 1'b0;
                end
                if (rx_rdy) begin
                    hi_d    = rx_data;
                    tmo_d   = '0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    cmd_d     = {hi_q, rx_data};
                    cmd_rdy_d = 1'b1;
                    state_d   = IDLE;
                end else if (rx_ferr) begin
                    state_d = IDLE;
                end else if (tmo_q >= TW'(TIMEOUT)) begin
                    state_d = IDLE;
                end else if (rx_idle) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
        endcase
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
module tb_cmd_uart_wrapper;
    import knight_pkg::*;

    localparam int B   = 16;
    localparam int H   = B / 2;
    localparam int TMO = 20 * B;
    // negedges from a start-bit edge until the cycle before cmd_rdy sets
    localparam int LAT = H + 3 + 9 * B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;

    int checks = 0;
    int fails  = 0;
    int rises  = 0;

    cmd_uart_wrapper #(
        .BAUD_DIV(B),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .trmt       (trmt),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge cmd_rdy) rises++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drives one 10-bit frame; starts and ends on a negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (TX !== 1'b1) begin fails++; $display("FAIL reset_tx: TX=%b expected 1", TX); end
        checks++; if (cmd !== 16'h0000) begin fails++; $display("FAIL reset_cmd: cmd=%h expected 0000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy: cmd_rdy=%b expected 0", cmd_rdy); end
        checks++; if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_done: tx_done=%b expected 0", tx_done); end
        rst = 1'b0;
        repeat (2 * B) @(negedge clk);
    endtask

    task automatic test_basic();
        send_byte(8'h20, 1'b1);
        fork
            send_byte(8'h00, 1'b1);
            begin
                repeat (LAT) @(negedge clk);
                checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL basic_rdy_early: cmd_rdy=%b expected 0", cmd_rdy); end
                @(negedge clk);
                checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL basic_rdy_lat: cmd_rdy=%b expected 1", cmd_rdy); end
                checks++; if (cmd !== 16'h2000) begin fails++; $display("FAIL basic_cmd: cmd=%h expected 2000", cmd); end
            end
        join
        pulse_clr();
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL basic_clr: cmd_rdy=%b expected 0", cmd_rdy); end
        checks++; if (cmd !== 16'h2000) begin fails++; $display("FAIL basic_cmd_hold: cmd=%h expected 2000", cmd); end
    endtask

    task automatic test_clr_collision();
        send_byte(8'h4B, 1'b1);
        send_byte(8'hF1, 1'b1);
        checks++; if (cmd !== 16'h4BF1) begin fails++; $display("FAIL coll_first_cmd: cmd=%h expected 4bf1", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL coll_first_rdy: cmd_rdy=%b expected 1", cmd_rdy); end
        send_byte(8'h40, 1'b1);
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL coll_start_clear: cmd_rdy=%b expected 0", cmd_rdy); end
        checks++; if (cmd !== 16'h4BF1) begin fails++; $display("FAIL coll_cmd_hold: cmd=%h expected 4bf1", cmd); end
        fork
            send_byte(8'h02, 1'b1);
            begin
                repeat (LAT) @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL coll_set_wins: cmd_rdy=%b expected 1", cmd_rdy); end
                checks++; if (cmd !== 16'h4002) begin fails++; $display("FAIL coll_cmd: cmd=%h expected 4002", cmd); end
            end
        join
        checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL coll_rdy_held: cmd_rdy=%b expected 1", cmd_rdy); end
        pulse_clr();
    endtask

    task automatic test_tx();
        logic [9:0] f;
        f = {1'b1, POS_ACK, 1'b0};
        resp = POS_ACK;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        repeat (H) @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            checks++; if (TX !== f[j]) begin fails++; $display("FAIL tx_bit%0d: TX=%b expected %b", j, TX, f[j]); end
            if (j == 3) begin
                resp = 8'h00;
                trmt = 1'b1;
                @(negedge clk);
                trmt = 1'b0;
                repeat (B - 1) @(negedge clk);
            end else if (j < 9) begin
                repeat (B) @(negedge clk);
            end
        end
        repeat (B - H - 1) @(negedge clk);
        checks++; if (tx_done !== 1'b0) begin fails++; $display("FAIL tx_done_early: tx_done=%b expected 0", tx_done); end
        @(negedge clk);
        checks++; if (tx_done !== 1'b1) begin fails++; $display("FAIL tx_done_set: tx_done=%b expected 1", tx_done); end
        checks++; if (TX !== 1'b1) begin fails++; $display("FAIL tx_idle: TX=%b expected 1", TX); end
    endtask

    task automatic test_back_to_back();
        resp = 8'h3C;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        checks++; if (tx_done !== 1'b0) begin fails++; $display("FAIL b2b_done_clr: tx_done=%b expected 0", tx_done); end
        checks++; if (TX !== 1'b0) begin fails++; $display("FAIL b2b_start: TX=%b expected 0", TX); end
        repeat (H + B) @(negedge clk);
        checks++; if (TX !== 1'b0) begin fails++; $display("FAIL b2b_bit0: TX=%b expected 0", TX); end
        repeat (2 * B) @(negedge clk);
        checks++; if (TX !== 1'b1) begin fails++; $display("FAIL b2b_bit2: TX=%b expected 1", TX); end
        repeat (7 * B - H) @(negedge clk);
        checks++; if (tx_done !== 1'b1) begin fails++; $display("FAIL b2b_done: tx_done=%b expected 1", tx_done); end
    endtask

    task automatic test_timeout();
        int r0;
        r0 = rises;
        send_byte(8'h40, 1'b1);
        repeat (TMO + 1) @(negedge clk);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        checks++; if (rises - r0 != 1) begin fails++; $display("FAIL tmo_rises: count=%0d expected 1", rises - r0); end
        checks++; if (cmd !== 16'h1234) begin fails++; $display("FAIL tmo_cmd: cmd=%h expected 1234", cmd); end
        pulse_clr();
    endtask

    task automatic test_framing();
        int r0;
        r0 = rises;
        send_byte(8'h55, 1'b0);
        RX = 1'b1;
        repeat (2 * B) @(negedge clk);
        checks++; if (cmd !== 16'h1234) begin fails++; $display("FAIL frm_cmd_hold: cmd=%h expected 1234", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL frm_no_rdy: cmd_rdy=%b expected 0", cmd_rdy); end
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
        checks++; if (rises - r0 != 1) begin fails++; $display("FAIL frm_rises: count=%0d expected 1", rises - r0); end
        checks++; if (cmd !== 16'h2000) begin fails++; $display("FAIL frm_cmd: cmd=%h expected 2000", cmd); end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h20, 1'b1);
        resp = POS_ACK;
        trmt = 1'b1;
        RX = 1'b0;
        @(negedge clk);
        trmt = 1'b0;
        repeat (4 * B) @(negedge clk);
        checks++; if (TX !== 1'b0) begin fails++; $display("FAIL rstm_pre_tx: TX=%b expected 0", TX); end
        rst = 1'b1;
        #1;
        checks++; if (TX !== 1'b1) begin fails++; $display("FAIL rstm_tx: TX=%b expected 1", TX); end
        checks++; if (cmd !== 16'h0000) begin fails++; $display("FAIL rstm_cmd: cmd=%h expected 0000", cmd); end
        checks++; if (cmd_rdy !== 1'b0) begin fails++; $display("FAIL rstm_rdy: cmd_rdy=%b expected 0", cmd_rdy); end
        checks++; if (tx_done !== 1'b0) begin fails++; $display("FAIL rstm_done: tx_done=%b expected 0", tx_done); end
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * B) @(negedge clk);
        send_byte(8'h4B, 1'b1);
        send_byte(8'hF1, 1'b1);
        checks++; if (cmd !== 16'h4BF1) begin fails++; $display("FAIL rstm_after_cmd: cmd=%h expected 4bf1", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin fails++; $display("FAIL rstm_after_rdy: cmd_rdy=%b expected 1", cmd_rdy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clr_collision();
        test_tx();
        test_back_to_back();
        test_timeout();
        test_framing();
        test_reset_midframe();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
